// File: rtl/cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cu_pkg: opcode/state enums and divide special-case results           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } cu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } cu_state_t;

  localparam logic [31:0] c_DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] c_OVF_QUOT  = 32'h8000_0000;
  localparam logic [31:0] c_OVF_REM   = 32'h0000_0000;
  localparam logic [31:0] c_INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] c_NEG_ONE   = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic i_en, input logic [31:0] i_val);
    return i_en ? (~i_val + 32'd1) : i_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cu_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cu_div_core: unsigned restoring divider, one quotient bit per step   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cu_div_core
  import cu_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  localparam int                 c_CNT_W = $clog2(DIV_ITERS);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV_ITERS - 1);

  logic [31:0]        r_quot;
  logic [32:0]        r_rem;
  logic [31:0]        r_div;
  logic [c_CNT_W-1:0] r_cnt;

  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_keep;

  // Dividend bits enter the remainder from the top of the quotient register.
  assign w_shift = {r_rem, r_quot[31]};
  assign w_diff  = w_shift - {2'b00, r_div};
  assign w_keep  = ~w_diff[33];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_rem  <= w_keep ? w_diff[32:0] : w_shift[32:0];
      r_quot <= {r_quot[30:0], w_keep};
      r_cnt  <= r_cnt + c_CNT_W'(1);
    end
  end

  assign o_done = i_step & (r_cnt == c_LAST);
  assign o_quot = r_quot;
  assign o_rem  = r_rem[31:0];

endmodule
`default_nettype wire

// File: rtl/complex_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | complex_unit: iterative RV32M multiply/divide responder              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module complex_unit
  import cu_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic        flush_i,
  input  logic        cu_valid_i,
  input  logic [2:0]  cu_opcode_i,
  input  logic [31:0] cu_operand1_i,
  input  logic [31:0] cu_operand2_i,
  output logic        busy_o,
  output logic [31:0] result_o,
  output logic        wb_valid_o
);

  cu_state_t   r_state;
  cu_state_t   w_next;
  cu_op_t      r_op;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic        r_sign1;
  logic        r_sign2;
  logic [31:0] r_result;
  logic        r_wb_valid;

  logic        w_accept;
  logic        w_start;
  logic        w_step;
  logic        w_set_wb;
  logic [31:0] w_wb_data;

  // Request-side decode, evaluated on the raw inputs at acceptance.
  logic        w_req_signed;
  logic        w_req_rem;
  logic        w_div_zero;
  logic        w_ovf;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;

  assign w_req_signed = ~cu_opcode_i[0];
  assign w_req_rem    = cu_opcode_i[1];
  assign w_div_zero   = (cu_operand2_i == 32'd0);
  assign w_ovf        = w_req_signed & (cu_operand1_i == c_INT_MIN) & (cu_operand2_i == c_NEG_ONE);
  assign w_abs1       = neg_if(w_req_signed & cu_operand1_i[31], cu_operand1_i);
  assign w_abs2       = neg_if(w_req_signed & cu_operand2_i[31], cu_operand2_i);

  // Multiply: 33-bit extended operands widened to 64 bits give the same low
  // 64 product bits as the 33x33 signed multiply.
  logic        w_ext1;
  logic        w_ext2;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;

  assign w_ext1    = ((r_op == OP_MULH) || (r_op == OP_MULHSU)) & r_sign1;
  assign w_ext2    = (r_op == OP_MULH) & r_sign2;
  assign w_mul_a   = {{32{w_ext1}}, r_op1};
  assign w_mul_b   = {{32{w_ext2}}, r_op2};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];

  logic        w_div_done;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_signed;
  logic        w_div_rem;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_div_res;

  cu_div_core #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div_core (
    .clk        (cpu_clk_i),
    .rst        (cpu_rst_i),
    .i_clear    (flush_i),
    .i_start    (w_start),
    .i_step     (w_step),
    .i_dividend (w_abs1),
    .i_divisor  (w_abs2),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_div_signed = (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_div_rem    = (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_quot_fix   = neg_if(w_div_signed & (r_sign1 ^ r_sign2), w_quot);
  assign w_rem_fix    = neg_if(w_div_signed & r_sign1, w_rem);
  assign w_div_res    = w_div_rem ? w_rem_fix : w_quot_fix;

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_start   = 1'b0;
    w_step    = 1'b0;
    w_set_wb  = 1'b0;
    w_wb_data = 32'd0;
    if (flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (cu_valid_i) begin
            w_accept = 1'b1;
            if (!cu_opcode_i[2]) begin
              w_next = MUL;
            end else if (w_div_zero) begin
              w_set_wb  = 1'b1;
              w_wb_data = w_req_rem ? cu_operand1_i : c_DIV0_QUOT;
            end else if (w_ovf) begin
              w_set_wb  = 1'b1;
              w_wb_data = w_req_rem ? c_OVF_REM : c_OVF_QUOT;
            end else begin
              w_start = 1'b1;
              w_next  = DIV;
            end
          end
        end
        MUL: begin
          w_set_wb  = 1'b1;
          w_wb_data = w_mul_res;
          w_next    = IDLE;
        end
        DIV: begin
          w_step = 1'b1;
          if (w_div_done) begin
            w_next = FIX;
          end
        end
        FIX: begin
          w_set_wb  = 1'b1;
          w_wb_data = w_div_res;
          w_next    = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      r_op       <= OP_MUL;
      r_op1      <= '0;
      r_op2      <= '0;
      r_sign1    <= 1'b0;
      r_sign2    <= 1'b0;
      r_result   <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid <= w_set_wb;
      if (w_set_wb) begin
        r_result <= w_wb_data;
      end
      if (w_accept) begin
        r_op    <= cu_op_t'(cu_opcode_i);
        r_op1   <= cu_operand1_i;
        r_op2   <= cu_operand2_i;
        r_sign1 <= cu_operand1_i[31];
        r_sign2 <= cu_operand2_i[31];
      end
    end
  end

  assign busy_o     = (r_state != IDLE);
  assign result_o   = r_result;
  assign wb_valid_o = r_wb_valid;

endmodule
`default_nettype wire
